// File: rtl/sum_accum.sv
// sum_accum: registered group accumulator downstream of the combinational
// sum adder. It takes WIDTH-bit beats over a valid/ready handshake and adds
// up to COUNT of them into an ACC_WIDTH-bit total. A group closes on its
// COUNT-th beat or on IN_flush. The total is then held for a downstream
// valid/ready transfer.
// Optional build macro SUM_ACCUM_SAT_EN: when defined, the accumulator
// saturates at all-ones instead of wrapping. OUT_ovf is set in both modes.
module sum_accum #(
  parameter int WIDTH     = 2,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         IN_sumValid,
  input  logic [WIDTH-1:0]             IN_sum,
  input  logic                         IN_flush,
  output logic                         OUT_sumReady,
  output logic                         OUT_accValid,
  input  logic                         IN_accReady,
  output logic [ACC_WIDTH-1:0]         OUT_acc,
  output logic [$clog2(COUNT+1)-1:0]   OUT_count,
  output logic                         OUT_ovf
);

  localparam int CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 accept;
  logic                 group_close;
  logic [ACC_WIDTH:0]   in_ext;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 carry;

  // Beats are unsigned. The extra top bit of the sum captures the carry-out.
  assign in_ext  = {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, IN_sum};
  assign sum_ext = {1'b0, acc_q} + in_ext;
  assign carry   = sum_ext[ACC_WIDTH];
  assign accept  = IN_sumValid && OUT_sumReady;

  // A beat arriving with a flush joins the group before the group closes.
  // A flush with nothing to emit is ignored.
  assign group_close = (accept && ((cnt_q == CNT_LAST) || IN_flush)) ||
                       (IN_flush && (cnt_q != '0));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: close a group into HOLD, and release it on a downstream accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (group_close) state_d = HOLD;
      HOLD:    if (IN_accReady) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Handshake outputs. They depend only on state and reset, never on IN_accReady.
  always_comb begin
    OUT_sumReady = 1'b0;
    OUT_accValid = 1'b0;
    if (!rst) begin
      OUT_sumReady = (state_q == ACCUM);
      OUT_accValid = (state_q == HOLD);
    end
  end

  // Accumulator next state: add while accumulating, freeze in HOLD, clear on transfer.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (state_q == ACCUM) begin
      if (accept) begin
        acc_d = sum_ext[ACC_WIDTH-1:0];
`ifdef SUM_ACCUM_SAT_EN
        // Once clamped, any further non-zero beat carries out again,
        // so the total stays pinned at all-ones for the rest of the group.
        if (carry) acc_d = '1;
`endif
        cnt_d = cnt_q + CW'(1);
        ovf_d = ovf_q | carry;
      end
    end else if (IN_accReady) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  // Accumulator registers. A reset discards any partial or pending group.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign OUT_acc   = acc_q;
  assign OUT_count = cnt_q;
  assign OUT_ovf   = ovf_q;

endmodule

// File: doc/sum_accum.md
# sum_accum

Registered accumulator stage directly downstream of the parameterized `Test` adder; it consumes that adder's `WIDTH`-bit sum result over a valid/ready handshake. It sums groups of up to `COUNT` beats into a wider accumulator and presents each group total downstream with a valid/ready handshake. A group closes on the `COUNT`-th beat or on an explicit flush. It is the first sequential element after the combinational sum path and decouples it from downstream backpressure.

## Interface
- `WIDTH`, default 2: width of the incoming sum beat; matches the upstream adder's `OUT_sum`.
- `ACC_WIDTH`, default 8: accumulator width; must be >= `WIDTH`.
- `COUNT`, default 4: maximum beats per group; must be >= 1.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `IN_sumValid`  in  1  upstream beat valid.
- `IN_sum`  in  `WIDTH`  upstream beat value, treated as unsigned.
- `IN_flush`  in  1  close the current group early.
- `OUT_sumReady`  out  1  stage can accept a beat this cycle.
- `OUT_accValid`  out  1  group result valid.
- `IN_accReady`  in  1  downstream accepts the result.
- `OUT_acc`  out  `ACC_WIDTH`  group total.
- `OUT_count`  out  `$clog2(COUNT+1)`  number of beats in the group.
- `OUT_ovf`  out  1  the accumulator carried out at least once during the group.

## Operation
- FSM states:
  - ACCUM (reset state).
  - HOLD.
- ACCUM behaviour:
  - `OUT_sumReady` = 1 and `OUT_accValid` = 0.
  - A beat is accepted when `IN_sumValid` && `OUT_sumReady`.
  - On accept: acc += zero-extended `IN_sum`, cnt += 1, and `ovf` is set if the add carries out of `ACC_WIDTH`.
- ACCUM → HOLD transitions:
  - On the cycle a beat is accepted with cnt == `COUNT`-1.
  - On `IN_flush` when cnt + accepted-this-cycle > 0.
  - If a beat and a flush arrive in the same cycle, the beat is included in the group before it closes.
  - `IN_flush` with an empty group and no beat is ignored; the state stays ACCUM.
- HOLD behaviour:
  - `OUT_accValid` = 1 and `OUT_sumReady` = 0.
  - `OUT_acc`, `OUT_count` and `OUT_ovf` are stable until the transfer completes.
  - `IN_flush` is ignored.
- HOLD → ACCUM: on `IN_accReady`, with acc, cnt and ovf cleared.
- Arithmetic: accumulation is modulo 2^`ACC_WIDTH`; `ovf` is sticky for the group.
- Reset while `rst` = 1:
  - State goes to ACCUM; acc, cnt and ovf are cleared.
  - All outputs are 0, including `OUT_sumReady`, which is forced to 0 during reset.
  - Reset mid-group or in HOLD discards the group without emitting it.

## Timing
- Result latency: `OUT_accValid` rises the cycle after the group-closing accept or flush.
- Minimum group period: cnt beats + 1 HOLD cycle; the stage takes no beats while in HOLD.
- `OUT_acc`, `OUT_count` and `OUT_ovf` come straight from registers, with no combinational path from any input.
- `OUT_sumReady` depends only on state and `rst`, with no combinational path from `IN_accReady`.
- `OUT_accValid` never drops without a handshake.

## Configuration
- `SUM_ACCUM_SAT_EN` defined:
  - Accumulation saturates: on carry-out, acc is clamped to all-ones and stays there for the group.
  - `ovf` is still set.
- `SUM_ACCUM_SAT_EN` undefined: modulo wrap as specified under Operation.

## Test plan
All scenarios use `WIDTH`=2, `ACC_WIDTH`=3, `COUNT`=4.
- Reset check: hold `rst` for 3 cycles with `IN_sumValid`=1 → all outputs 0, no beat accepted; `OUT_sumReady`=1 on the first cycle after `rst` deasserts.
- Basic group: beats 1, 2, 0, 3 back-to-back with `IN_accReady`=1 → the cycle after the 4th beat shows `OUT_accValid`=1, `OUT_acc`=6, `OUT_count`=4, `OUT_ovf`=0; ACCUM resumes the next cycle.
- Overflow: beats 3, 3, 3, 3 → `OUT_acc`=4 and `OUT_ovf`=1 when wrapping; `OUT_acc`=7 and `OUT_ovf`=1 with `SUM_ACCUM_SAT_EN`.
- Backpressure: complete a group, then hold `IN_accReady`=0 for 5 cycles while `IN_sumValid`=1 with `IN_sum`=2 → outputs stable, `OUT_sumReady`=0, no beat consumed; releasing gives one transfer, then the pending beat is accepted into a fresh group.
- Flush:
  - Beats 2, 1, then beat 3 together with `IN_flush` → `OUT_acc`=6, `OUT_count`=3.
  - `IN_flush` with an empty group → no result emitted.
- Mid-group reset: beats 1, 1, then pulse `rst` → no result emitted; a following group of 2, 2, 2, 2 gives `OUT_acc`=0 and `OUT_ovf`=1 when wrapping.
